// File: rtl/light_fade_pwm.sv
// light_fade_pwm: turns the 3-bit light state from the light FSM into a PWM
// lamp drive whose duty ramps toward the requested level by FADE_STEP per
// PWM period. The duty only moves on the period wrap, so a period never
// contains a partial (runt) pulse.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_reset       asynchronous active-low reset
//   i_lightState  requested light state (0 off, 1..4 quarter steps, 5..7 off)
//   o_light       registered PWM lamp drive
//   o_duty        currently applied duty in PWM ticks (0..2^CNT_WIDTH)
//   o_busy        high while the duty is still ramping toward the target
//   o_periodEnd   one-clock pulse in the clock after each PWM period wrap
module light_fade_pwm #(
    parameter int unsigned CNT_WIDTH = 10,
    parameter int unsigned TICK_DIV  = 100,
    parameter int unsigned FADE_STEP = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [2:0]           i_lightState,
    output logic                 o_light,
    output logic [CNT_WIDTH:0]   o_duty,
    output logic                 o_busy,
    output logic                 o_periodEnd
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DUTY_W  = CNT_WIDTH + 1;
    // Two headroom bits so duty+step and target+step never wrap.
    localparam int unsigned ARITH_W = CNT_WIDTH + 2;

    localparam logic [PRESC_W-1:0]   PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [DUTY_W-1:0]    LVL_FULL  = DUTY_W'(2 ** CNT_WIDTH);
    localparam logic [DUTY_W-1:0]    LVL_HALF  = DUTY_W'(2 ** CNT_WIDTH / 2);
    localparam logic [DUTY_W-1:0]    LVL_QTR   = DUTY_W'(2 ** CNT_WIDTH / 4);
    localparam logic [DUTY_W-1:0]    LVL_3QTR  = DUTY_W'(2 ** CNT_WIDTH / 2 + 2 ** CNT_WIDTH / 4);
    localparam logic [ARITH_W-1:0]   STEP      = ARITH_W'(FADE_STEP);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FADE_UP   = 2'd1,
        ST_FADE_DOWN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PRESC_W-1:0]     presc_q, presc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DUTY_W-1:0]      target_q, target_d;
    logic [DUTY_W-1:0]      duty_q, duty_d;
    logic                   busy_q, busy_d;
    logic                   light_q, light_d;
    logic                   period_end_q, period_end_d;

    logic                   tick_c;
    logic                   wrap_c;
    logic [ARITH_W-1:0]     duty_ext_c;
    logic [ARITH_W-1:0]     tgt_ext_c;
    logic [ARITH_W-1:0]     up_sum_c;
    logic [ARITH_W-1:0]     stepped_c;
    logic [DUTY_W-1:0]      duty_step_c;

    // Prescaler and PWM counter; the counter wraps naturally at its width.
    always_comb begin
        tick_c  = (presc_q == PRESC_MAX);
        presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
        cnt_d   = tick_c ? cnt_q + CNT_WIDTH'(1) : cnt_q;
        wrap_c  = tick_c && (cnt_q == CNT_MAX);
    end

    // Requested state sampled every clock and mapped to a target duty.
    always_comb begin
        target_d = '0;
        case (i_lightState)
            3'd1:    target_d = LVL_QTR;
            3'd2:    target_d = LVL_HALF;
            3'd3:    target_d = LVL_3QTR;
            3'd4:    target_d = LVL_FULL;
            default: target_d = '0;
        endcase
    end

    // One fade step toward the target, clamped so it never overshoots.
    always_comb begin
        duty_ext_c = ARITH_W'(duty_q);
        tgt_ext_c  = ARITH_W'(target_q);
        up_sum_c   = duty_ext_c + STEP;
        stepped_c  = duty_ext_c;
        if (duty_ext_c < tgt_ext_c) begin
            stepped_c = (up_sum_c > tgt_ext_c) ? tgt_ext_c : up_sum_c;
        end else if (duty_ext_c > tgt_ext_c) begin
            stepped_c = (duty_ext_c >= tgt_ext_c + STEP) ? duty_ext_c - STEP : tgt_ext_c;
        end
        // Result lies between duty and target, both <= 2^CNT_WIDTH.
        duty_step_c = DUTY_W'(stepped_c);
    end

    // Fade FSM: duty and state only advance on the period wrap.
    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        period_end_d = wrap_c;
        light_d      = ({1'b0, cnt_q} < duty_q);
        if (wrap_c) begin
            duty_d = duty_step_c;
            if (duty_step_c < target_q) begin
                state_d = ST_FADE_UP;
            end else if (duty_step_c > target_q) begin
                state_d = ST_FADE_DOWN;
            end else begin
                state_d = ST_IDLE;
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            cnt_q        <= '0;
            target_q     <= '0;
            duty_q       <= '0;
            busy_q       <= 1'b0;
            light_q      <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            duty_q       <= duty_d;
            busy_q       <= busy_d;
            light_q      <= light_d;
            period_end_q <= period_end_d;
        end
    end

    assign o_light     = light_q;
    assign o_duty      = duty_q;
    assign o_busy      = busy_q;
    assign o_periodEnd = period_end_q;

endmodule
